// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one external approximate multiplier
// among NREQ requesters and returns id-tagged results through a stallable pipeline.
module mult_share_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int NREQ     = 4,
    parameter int MUL_LAT  = 2,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITWIDTH-1:0] req_a,
    input  logic [NREQ*BITWIDTH-1:0] req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [BITWIDTH-1:0]      mul_a,
    output logic [BITWIDTH-1:0]      mul_b,
    input  logic [BITWIDTH-1:0]      mul_r,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [BITWIDTH-1:0]      rsp_r,
    output logic                     busy
);

    // Handshake: a transfer happens on any edge where valid & ready are both high;
    // ready never depends on the same requester's payload, only on valid and stall.
    logic                advance;
    logic                accept;
    logic                found;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      grant_idx;
    logic [NREQ-1:0]     grant;
    logic [BITWIDTH-1:0] sel_a;
    logic [BITWIDTH-1:0] sel_b;
    logic                busy_next;

    logic                s1_v;
    logic [IDW-1:0]      s1_id;
    logic [BITWIDTH-1:0] s1_a;
    logic [BITWIDTH-1:0] s1_b;

    logic [MUL_LAT:2]    st_v;
    logic [IDW-1:0]      st_id [2:MUL_LAT];
    logic [BITWIDTH-1:0] st_r  [2:MUL_LAT];

    assign advance = ~st_v[MUL_LAT] | rsp_ready;

    // Search upward from the pointer, wrapping past NREQ-1 back to 0.
    always_comb begin
        int j;
        j         = 0;
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int off = 0; off < NREQ; off++) begin
            j = int'(ptr) + off;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found     = 1'b1;
                grant_idx = IDW'(j);
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_a = req_a[i*BITWIDTH +: BITWIDTH];
                sel_b = req_b[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    assign req_ready = (rst_n && advance) ? grant : '0;
    assign accept    = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Operand registers keep their old value on idle cycles so the multiplier stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_id <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
        end else if (advance) begin
            s1_v <= accept;
            if (accept) begin
                s1_id <= grant_idx;
                s1_a  <= sel_a;
                s1_b  <= sel_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v <= '0;
            for (int s = 2; s <= MUL_LAT; s++) begin
                st_id[s] <= '0;
                st_r[s]  <= '0;
            end
        end else if (advance) begin
            st_v[2]  <= s1_v;
            st_id[2] <= s1_id;
            st_r[2]  <= mul_r;
            for (int s = 3; s <= MUL_LAT; s++) begin
                st_v[s]  <= st_v[s-1];
                st_id[s] <= st_id[s-1];
                st_r[s]  <= st_r[s-1];
            end
        end
    end

    // busy reflects the stage valids as they will be after this edge.
    always_comb begin
        busy_next = accept | s1_v;
        for (int s = 2; s < MUL_LAT; s++) begin
            busy_next = busy_next | st_v[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (advance) begin
            busy <= busy_next;
        end
    end

    assign mul_a     = s1_a;
    assign mul_b     = s1_b;
    assign rsp_valid = st_v[MUL_LAT];
    assign rsp_id    = st_id[MUL_LAT];
    assign rsp_r     = st_r[MUL_LAT];

endmodule
